ahb_slave_mux: RTL and testbench
================================

# ahb_slave_mux

AHB slave-to-master response multiplexer with a built-in default slave and a wait-state watchdog. It sits directly downstream of the address decoder. It captures the decoder's one-hot slave select in the address phase and routes the selected slave's HRDATA/HREADYOUT/HRESP to the master in the data phase. Unmapped transfers get a two-cycle ERROR response, as do slaves that stall beyond a timeout.

## Interface
- SLAVE_DEVICES, 4: number of slaves; width of the select and response vectors.
- AHB_DATA_WIDTH, 32: HRDATA width.
- TIMEOUT_CYCLES, 16: maximum consecutive wait states tolerated from a slave; must be at least 2.
- ahb_clk_in  in  1  AHB clock.
- ahb_rstn_in  in  1  reset.
  - Reset ahb_rstn_in, asynchronous, active-low; clock ahb_clk_in.
- ahb_htrans_in  in  2  master HTRANS of the current address phase.
- slave_sel_in  in  SLAVE_DEVICES  one-hot address-phase select from the decoder.
- slave_hrdata_in  in  SLAVE_DEVICES*AHB_DATA_WIDTH  slave read data; slave i occupies bits [i*DW +: DW].
- slave_hreadyout_in  in  SLAVE_DEVICES  per-slave HREADYOUT.
- slave_hresp_in  in  SLAVE_DEVICES  per-slave HRESP (1 = ERROR).
- ahb_hready_out  out  1  combined HREADY to the master, all slaves and the decoder.
- ahb_hresp_out  out  1  combined HRESP.
- ahb_hrdata_out  out  AHB_DATA_WIDTH  combined HRDATA.
- timeout_flag_out  out  1  registered one-cycle pulse on watchdog expiry.

## Operation
- State machine states: ST_IDLE, ST_SLAVE, ST_ERR1, ST_ERR2.
- Address-phase sampling happens only in cycles where ahb_hready_out=1. The next state is decided as follows:
  - htrans[1]=0 (IDLE or BUSY) → ST_IDLE.
  - htrans[1]=1 and slave_sel_in exactly one-hot → ST_SLAVE. The data-phase select register dsel loads slave_sel_in.
  - htrans[1]=1 and slave_sel_in zero or multi-hot → ST_ERR1.
- ST_IDLE outputs: hready=1, hresp=0, hrdata=0.
- ST_SLAVE outputs: hready, hresp and hrdata are combinational copies of the dsel slave's signals.
  - A slave's own two-cycle ERROR response passes through unchanged.
- ST_ERR1 outputs: hready=0, hresp=1, hrdata=0. The next state is always ST_ERR2.
- ST_ERR2 outputs: hready=1, hresp=1, hrdata=0. The next state is decided by address sampling.
- Watchdog counter: $clog2(TIMEOUT_CYCLES)+1 bits.
  - Cleared on every entry to ST_SLAVE.
  - Increments in each ST_SLAVE cycle where the selected hreadyout=0.
  - When count == TIMEOUT_CYCLES-1 and hreadyout is still 0, the next state is ST_ERR1. dsel clears to 0 and timeout_flag_out=1 during that ST_ERR1 cycle.
  - The slave's hready=0 in that expiry cycle is still passed through.
- The counter saturates and never wraps.
- ST_ERR1 ignores slave inputs, so a slave that is late or still stalled cannot corrupt the ERROR response.
- Expiry and slave ready in the same cycle: ready wins, the transfer completes normally and no timeout occurs.

## Timing
- Reset values: state ST_IDLE, dsel 0, counter 0, ahb_hready_out 1, ahb_hresp_out 0, ahb_hrdata_out 0, timeout_flag_out 0.
- Data-phase routing is combinational with zero added latency. Only state, dsel, the counter and timeout_flag_out are registered.
- Unmapped transfer: ERROR occupies exactly 2 data-phase cycles (hready 0 then 1). The next address is sampled in the ST_ERR2 cycle.
- Back-to-back transfers: the address of transfer N+1 is sampled in the cycle where transfer N completes (hready=1). There are no bubbles.
- A reset asserted mid-transfer forces reset values immediately, asynchronously. The transfer in progress is abandoned.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11.
  - HRESP_OKAY 1'b0 and HRESP_ERROR 1'b1.
  - The mux state encoding.
- One sub-module, ahb_resp_timer: the watchdog counter with clear, enable and expiry outputs.
- The one-hot check and the read-data mux stay inline.

## Test plan
- Reset released with htrans=IDLE → hready=1, hresp=0, hrdata=0, timeout_flag=0 on every cycle.
- NONSEQ, sel=4'b0010; slave1 hreadyout=0 for 2 cycles then 1 with data 32'hA5A5_0001 → hready 0,0,1; hrdata=32'hA5A5_0001 in the completing cycle.
- NONSEQ, sel=4'b0000 → next two cycles are hready=0/hresp=1, then hready=1/hresp=1, hrdata=0.
- NONSEQ, sel=4'b0101 (multi-hot) → same two-cycle ERROR; neither slave's data appears.
- NONSEQ to slave3 with hreadyout held at 0 and TIMEOUT_CYCLES=16:
  - hready is low for 16 cycles.
  - timeout_flag=1 for exactly one cycle, together with hresp=1/hready=0, followed by hresp=1/hready=1.
- Back-to-back NONSEQ to slave0 then slave2, zero wait → consecutive cycles show slave0 data then slave2 data. Asserting reset mid-wait restores all reset values.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings and response-mux state type
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLAVE = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } mux_state_e;

endpackage

// File: rtl/ahb_resp_timer.sv
// rtl/ahb_resp_timer.sv - saturating wait-state watchdog for the response mux
module ahb_resp_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic ahb_clk_in,
    input  logic ahb_rstn_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic expire_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is only meaningful while the slave is still stalling.
    assign expire_out = enable_in && (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (enable_in && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// rtl/ahb_slave_mux.sv - AHB slave response mux with default slave and wait-state watchdog
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int SLAVE_DEVICES  = 4,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                    ahb_clk_in,
    input  logic                                    ahb_rstn_in,
    input  logic [1:0]                              ahb_htrans_in,
    input  logic [SLAVE_DEVICES-1:0]                slave_sel_in,
    input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_hrdata_in,
    input  logic [SLAVE_DEVICES-1:0]                slave_hreadyout_in,
    input  logic [SLAVE_DEVICES-1:0]                slave_hresp_in,
    output logic                                    ahb_hready_out,
    output logic                                    ahb_hresp_out,
    output logic [AHB_DATA_WIDTH-1:0]               ahb_hrdata_out,
    output logic                                    timeout_flag_out
);

    mux_state_e                state_q, state_d;
    logic [SLAVE_DEVICES-1:0]  dsel_q, dsel_d;
    logic                      timeout_flag_q, timeout_flag_d;

    logic                      sel_ready;
    logic                      sel_resp;
    logic [AHB_DATA_WIDTH-1:0] sel_data;
    logic                      sel_onehot;
    logic                      trans_active;
    logic                      sample;
    logic                      timer_clear;
    logic                      timer_enable;
    logic                      timer_expire;

    assign sel_onehot   = (slave_sel_in != '0) &&
                          ((slave_sel_in & (slave_sel_in - 1'b1)) == '0);
    assign trans_active = (ahb_htrans_in == HTRANS_NONSEQ) || (ahb_htrans_in == HTRANS_SEQ);
    assign sel_ready    = |(dsel_q & slave_hreadyout_in);
    assign sel_resp     = |(dsel_q & slave_hresp_in);
    assign timer_enable = (state_q == ST_SLAVE) && !sel_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < SLAVE_DEVICES; i++) begin
            if (dsel_q[i]) begin
                sel_data = sel_data | slave_hrdata_in[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
            end
        end
    end

    ahb_resp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .ahb_clk_in (ahb_clk_in),
        .ahb_rstn_in(ahb_rstn_in),
        .clear_in   (timer_clear),
        .enable_in  (timer_enable),
        .expire_out (timer_expire)
    );

    always_comb begin
        state_d        = state_q;
        dsel_d         = dsel_q;
        timeout_flag_d = 1'b0;
        sample         = 1'b0;
        timer_clear    = 1'b0;
        ahb_hready_out = 1'b1;
        ahb_hresp_out  = HRESP_OKAY;
        ahb_hrdata_out = '0;

        case (state_q)
            ST_IDLE: begin
                sample = 1'b1;
            end
            ST_SLAVE: begin
                ahb_hready_out = sel_ready;
                ahb_hresp_out  = sel_resp;
                ahb_hrdata_out = sel_data;
                if (timer_expire) begin
                    state_d        = ST_ERR1;
                    dsel_d         = '0;
                    timeout_flag_d = 1'b1;
                end else if (sel_ready) begin
                    sample = 1'b1;
                end
            end
            ST_ERR1: begin
                ahb_hready_out = 1'b0;
                ahb_hresp_out  = HRESP_ERROR;
                state_d        = ST_ERR2;
            end
            ST_ERR2: begin
                ahb_hresp_out = HRESP_ERROR;
                sample        = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                dsel_d  = '0;
            end
        endcase

        // Address phase of the next transfer overlaps the completing data phase.
        if (sample) begin
            if (!trans_active) begin
                state_d = ST_IDLE;
                dsel_d  = '0;
            end else if (sel_onehot) begin
                state_d     = ST_SLAVE;
                dsel_d      = slave_sel_in;
                timer_clear = 1'b1;
            end else begin
                state_d = ST_ERR1;
                dsel_d  = '0;
            end
        end
    end

    assign timeout_flag_out = timeout_flag_q;

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state_q        <= ST_IDLE;
            dsel_q         <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dsel_q         <= dsel_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// tb/tb_ahb_slave_mux.sv - directed vector bench for ahb_slave_mux
module tb_ahb_slave_mux;
    import ahb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam logic [DW-1:0] D0 = 32'h1111_0000;
    localparam logic [DW-1:0] D1 = 32'hA5A5_0001;
    localparam logic [DW-1:0] D2 = 32'h2222_0002;
    localparam logic [DW-1:0] D3 = 32'h3333_0003;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [1:0]    htrans = HTRANS_IDLE;
    logic [NS-1:0] sel = '0;
    logic [NS*DW-1:0] hrdata_bus;
    logic [NS-1:0] rdy = '1;
    logic [NS-1:0] resp = '0;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          tflag;

    int total = 0;
    int bad   = 0;

    assign hrdata_bus = {D3, D2, D1, D0};

    always #5 clk = ~clk;

    ahb_slave_mux #(
        .SLAVE_DEVICES (NS),
        .AHB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ahb_clk_in        (clk),
        .ahb_rstn_in       (rstn),
        .ahb_htrans_in     (htrans),
        .slave_sel_in      (sel),
        .slave_hrdata_in   (hrdata_bus),
        .slave_hreadyout_in(rdy),
        .slave_hresp_in    (resp),
        .ahb_hready_out    (hready),
        .ahb_hresp_out     (hresp),
        .ahb_hrdata_out    (hrdata),
        .timeout_flag_out  (tflag)
    );

    typedef struct {
        logic [1:0]    htrans;
        logic [NS-1:0] sel;
        logic [NS-1:0] rdy;
        logic [NS-1:0] resp;
        logic          e_ready;
        logic          e_resp;
        logic [DW-1:0] e_data;
        logic          e_flag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] t, input logic [NS-1:0] s, input logic [NS-1:0] r,
                       input logic [NS-1:0] p, input logic er, input logic ep,
                       input logic [DW-1:0] ed, input logic ef);
        vec_t v;
        v.htrans = t; v.sel = s; v.rdy = r; v.resp = p;
        v.e_ready = er; v.e_resp = ep; v.e_data = ed; v.e_flag = ef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic [NS-1:0] s,
                         input logic [NS-1:0] r, input logic [NS-1:0] p);
        @(negedge clk);
        htrans = t; sel = s; rdy = r; resp = p;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic er, input logic ep,
                           input logic [DW-1:0] ed, input logic ef);
        chk({tag, ".hready"}, {31'd0, hready}, {31'd0, er});
        chk({tag, ".hresp"},  {31'd0, hresp},  {31'd0, ep});
        chk({tag, ".hrdata"}, hrdata, ed);
        chk({tag, ".tflag"},  {31'd0, tflag},  {31'd0, ef});
    endtask

    initial begin
        // idle after reset
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 0);
        // slave1 with two wait states
        add(HTRANS_NONSEQ, 4'b0010, 4'b1111, 4'b0000, 1, 0, '0, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1101, 4'b0000, 0, 0, D1, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1101, 4'b0000, 0, 0, D1, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, D1, 0);
        // unmapped, then multi-hot sampled in ERR2
        add(HTRANS_NONSEQ, 4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 0, 1, '0, 0);
        add(HTRANS_NONSEQ, 4'b0101, 4'b1111, 4'b0000, 1, 1, '0, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 0, 1, '0, 0);
        // back-to-back slave0 then slave2
        add(HTRANS_NONSEQ, 4'b0001, 4'b1111, 4'b0000, 1, 1, '0, 0);
        add(HTRANS_NONSEQ, 4'b0100, 4'b1111, 4'b0000, 1, 0, D0, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, D2, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 0);
        // slave3 two-cycle ERROR passes through
        add(HTRANS_NONSEQ, 4'b1000, 4'b1111, 4'b0000, 1, 0, '0, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b0111, 4'b1000, 0, 1, D3, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b1000, 1, 1, D3, 0);
        // SEQ accepted, BUSY treated as idle
        add(HTRANS_SEQ,    4'b0010, 4'b1111, 4'b0000, 1, 0, '0, 0);
        add(HTRANS_BUSY,   4'b0010, 4'b1111, 4'b0000, 1, 0, D1, 0);
        add(HTRANS_IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 0);

        #1;
        chk_all("reset", 1, 0, '0, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].htrans, vecs[i].sel, vecs[i].rdy, vecs[i].resp);
            chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_resp,
                    vecs[i].e_data, vecs[i].e_flag);
        end

        // watchdog expiry on slave3
        drive(HTRANS_NONSEQ, 4'b1000, 4'b1111, 4'b0000);
        chk_all("to.addr", 1, 0, '0, 0);
        for (int i = 0; i < TO; i++) begin
            drive(HTRANS_IDLE, 4'b0000, 4'b0111, 4'b0000);
            chk_all($sformatf("to.wait%0d", i), 0, 0, D3, 0);
        end
        drive(HTRANS_IDLE, 4'b0000, 4'b0111, 4'b0000);
        chk_all("to.err1", 0, 1, '0, 1);
        drive(HTRANS_IDLE, 4'b0000, 4'b0111, 4'b0000);
        chk_all("to.err2", 1, 1, '0, 0);
        drive(HTRANS_IDLE, 4'b0000, 4'b1111, 4'b0000);
        chk_all("to.idle", 1, 0, '0, 0);

        // ready arriving in the would-be expiry cycle wins
        drive(HTRANS_NONSEQ, 4'b1000, 4'b1111, 4'b0000);
        for (int i = 0; i < TO - 1; i++) begin
            drive(HTRANS_IDLE, 4'b0000, 4'b0111, 4'b0000);
            chk_all($sformatf("rw.wait%0d", i), 0, 0, D3, 0);
        end
        drive(HTRANS_IDLE, 4'b0000, 4'b1111, 4'b0000);
        chk_all("rw.done", 1, 0, D3, 0);
        drive(HTRANS_IDLE, 4'b0000, 4'b1111, 4'b0000);
        chk_all("rw.after", 1, 0, '0, 0);

        // asynchronous reset in the middle of a stalled transfer
        drive(HTRANS_NONSEQ, 4'b0100, 4'b1111, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(HTRANS_IDLE, 4'b0000, 4'b1011, 4'b0000);
            chk_all($sformatf("rst.wait%0d", i), 0, 0, D2, 0);
        end
        rstn = 1'b0;
        #1;
        chk_all("rst.async", 1, 0, '0, 0);
        @(negedge clk);
        rstn = 1'b1;
        drive(HTRANS_IDLE, 4'b0000, 4'b1011, 4'b0000);
        chk_all("rst.after", 1, 0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
